// File: rtl/numberle_round_controller.sv
// One Numberle round: loads a secret, collects a 4-digit guess with a cursor,
// grades each submitted guess digit by digit and declares win or lose.
module numberle_round_controller #(
  parameter int unsigned MAX_TRIES = 7
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        btn_new_game,
  input  logic        btn_next,
  input  logic        btn_submit,
  input  logic        key_valid,
  input  logic [3:0]  key_value,
  input  logic        secret_valid,
  input  logic [15:0] secret_in,
  output logic        secret_req,
  output logic [15:0] digits_out,
  output logic [1:0]  cursor,
  output logic [11:0] feedback,
  output logic [3:0]  tries_used,
  output logic [3:0]  msg_code,
  output logic        win,
  output logic        lose,
  output logic [2:0]  state_code
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    ENTRY    = 3'd2,
    CHECK    = 3'd3,
    FEEDBACK = 3'd4,
    WIN      = 3'd5,
    LOSE     = 3'd6
  } state_t;

  state_t      state;
  logic [15:0] secret;

  logic [15:0] secret_clean;
  logic [11:0] check_fb;
  logic        check_hit;
  logic        entry_blank;
  logic [3:0]  tries_inc;

  // Grading and input cleanup are pure functions of the current registers.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    secret_clean = '0;
    check_fb     = '0;
    entry_blank  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      secret_clean[4*i +: 4] = (secret_in[4*i +: 4] > 4'd9) ?
                               {1'b0, secret_in[4*i + 2 -: 3]} : secret_in[4*i +: 4];
      check_fb[3*i +: 3]     = {digits_out[4*i +: 4] >  secret[4*i +: 4],
                                digits_out[4*i +: 4] == secret[4*i +: 4],
                                digits_out[4*i +: 4] <  secret[4*i +: 4]};
      if (digits_out[4*i +: 4] == 4'hF) entry_blank = 1'b1;
    end
    check_hit = (check_fb == 12'b010_010_010_010);
    tries_inc = tries_used + 4'd1;
  end

  assign state_code = state;

  // NOTE: all state updates are non-blocking so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      secret     <= 16'hFFFF;
      digits_out <= 16'hFFFF;
      cursor     <= 2'd0;
      feedback   <= 12'd0;
      tries_used <= 4'd0;
      secret_req <= 1'b0;
      msg_code   <= 4'd0;
      win        <= 1'b0;
      lose       <= 1'b0;
    end else if (btn_new_game && state != LOAD) begin
      state      <= LOAD;
      digits_out <= 16'hFFFF;
      cursor     <= 2'd0;
      feedback   <= 12'd0;
      tries_used <= 4'd0;
      secret_req <= 1'b1;
      msg_code   <= 4'd0;
      win        <= 1'b0;
      lose       <= 1'b0;
    end else begin
      unique case (state)
        LOAD: if (secret_valid) begin
          secret     <= secret_clean;
          secret_req <= 1'b0;
          state      <= ENTRY;
          msg_code   <= tries_inc;
        end
        ENTRY: begin
          if (btn_submit) begin
            // A submit with any blank digit is silently dropped.
            if (!entry_blank) begin
              state    <= CHECK;
              msg_code <= tries_used;
            end
          end else begin
            if (key_valid && key_value <= 4'd9) digits_out[{cursor, 2'b00} +: 4] <= key_value;
            if (btn_next) cursor <= cursor + 2'd1;
          end
        end
        CHECK: begin
          feedback   <= check_fb;
          tries_used <= tries_inc;
          if (check_hit) begin
            state    <= WIN;
            win      <= 1'b1;
            msg_code <= 4'hA;
          end else if (tries_inc == 4'(MAX_TRIES)) begin
            state    <= LOSE;
            lose     <= 1'b1;
            msg_code <= 4'hD;
          end else begin
            state    <= FEEDBACK;
            msg_code <= tries_inc;
          end
        end
        FEEDBACK: if (btn_submit) begin
          state      <= ENTRY;
          digits_out <= 16'hFFFF;
          cursor     <= 2'd0;
          msg_code   <= tries_used + 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_numberle_round_controller.sv
// Self-checking bench: directed round scenarios plus random traffic, all compared
// cycle by cycle against a digit-array model of the game rules.
module tb_numberle_round_controller;

  localparam int MAX_TRIES = 7;

  logic        clock = 1'b0;
  logic        reset, btn_new_game, btn_next, btn_submit, key_valid, secret_valid;
  logic [3:0]  key_value;
  logic [15:0] secret_in;
  logic        secret_req, win, lose;
  logic [15:0] digits_out;
  logic [1:0]  cursor;
  logic [11:0] feedback;
  logic [3:0]  tries_used, msg_code;
  logic [2:0]  state_code;

  int checks = 0;
  int errors = 0;

  // Model state: codes 0..6 as in state_code; digits/secret kept as int arrays.
  int m_state, m_cur, m_tries, m_msg;
  int m_dig[4];
  int m_sec[4];
  int m_fb[4];
  bit m_req, m_win, m_lose;

  numberle_round_controller #(.MAX_TRIES(MAX_TRIES)) dut (
    .clock(clock), .reset(reset), .btn_new_game(btn_new_game), .btn_next(btn_next),
    .btn_submit(btn_submit), .key_valid(key_valid), .key_value(key_value),
    .secret_valid(secret_valid), .secret_in(secret_in), .secret_req(secret_req),
    .digits_out(digits_out), .cursor(cursor), .feedback(feedback),
    .tries_used(tries_used), .msg_code(msg_code), .win(win), .lose(lose),
    .state_code(state_code)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_cur = 0; m_tries = 0; m_msg = 0;
    m_req = 0; m_win = 0; m_lose = 0;
    for (int i = 0; i < 4; i++) begin
      m_dig[i] = 15; m_sec[i] = 15; m_fb[i] = 0;
    end
  endtask

  // Applies the game rules to the inputs present at the clock edge.
  task automatic model_step();
    int hits;
    bit blank;
    if (reset) begin
      model_reset();
    end else if (btn_new_game && m_state != 1) begin
      m_state = 1; m_cur = 0; m_tries = 0; m_msg = 0;
      m_req = 1; m_win = 0; m_lose = 0;
      for (int i = 0; i < 4; i++) begin m_dig[i] = 15; m_fb[i] = 0; end
    end else begin
      case (m_state)
        1: if (secret_valid) begin
          for (int i = 0; i < 4; i++) begin
            m_sec[i] = (secret_in >> (4*i)) & 15;
            if (m_sec[i] > 9) m_sec[i] -= 8;
          end
          m_req = 0; m_state = 2; m_msg = m_tries + 1;
        end
        2: begin
          if (btn_submit) begin
            blank = 0;
            foreach (m_dig[i]) if (m_dig[i] == 15) blank = 1;
            if (!blank) begin m_state = 3; m_msg = m_tries; end
          end else begin
            if (key_valid && key_value <= 9) m_dig[m_cur] = key_value;
            if (btn_next) m_cur = (m_cur + 1) % 4;
          end
        end
        3: begin
          hits = 0;
          m_tries++;
          for (int i = 0; i < 4; i++) begin
            if (m_dig[i] < m_sec[i]) m_fb[i] = 1;
            else if (m_dig[i] == m_sec[i]) begin m_fb[i] = 2; hits++; end
            else m_fb[i] = 4;
          end
          if (hits == 4) begin m_state = 5; m_win = 1; m_msg = 10; end
          else if (m_tries == MAX_TRIES) begin m_state = 6; m_lose = 1; m_msg = 13; end
          else begin m_state = 4; m_msg = m_tries; end
        end
        4: if (btn_submit) begin
          m_state = 2; m_cur = 0; m_msg = m_tries + 1;
          for (int i = 0; i < 4; i++) m_dig[i] = 15;
        end
        default: ;
      endcase
    end
  endtask

  task automatic compare_all();
    logic [15:0] exp_dig;
    logic [11:0] exp_fb;
    exp_dig = '0;
    exp_fb  = '0;
    for (int i = 0; i < 4; i++) begin
      exp_dig = exp_dig | (16'(m_dig[i]) << (4*i));
      exp_fb  = exp_fb  | (12'(m_fb[i])  << (3*i));
    end
    check("state_code", 32'(state_code), 32'(m_state));
    check("digits_out", 32'(digits_out), 32'(exp_dig));
    check("cursor",     32'(cursor),     32'(m_cur));
    check("feedback",   32'(feedback),   32'(exp_fb));
    check("tries_used", 32'(tries_used), 32'(m_tries));
    check("msg_code",   32'(msg_code),   32'(m_msg));
    check("secret_req", 32'(secret_req), 32'(m_req));
    check("win",        32'(win),        32'(m_win));
    check("lose",       32'(lose),       32'(m_lose));
    check("win_lose_exclusive", 32'(win & lose), 32'd0);
  endtask

  task automatic step(input logic rst, input logic ng, input logic sub, input logic nx,
                      input logic kv, input logic [3:0] kval,
                      input logic sv, input logic [15:0] sec);
    reset = rst; btn_new_game = ng; btn_submit = sub; btn_next = nx;
    key_valid = kv; key_value = kval; secret_valid = sv; secret_in = sec;
    @(posedge clock);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic idle();                        step(0, 0, 0, 0, 0, 4'd0, 0, 16'h0); endtask
  task automatic new_game();                    step(0, 1, 0, 0, 0, 4'd0, 0, 16'h0); endtask
  task automatic submit();                      step(0, 0, 1, 0, 0, 4'd0, 0, 16'h0); endtask
  task automatic next();                        step(0, 0, 0, 1, 0, 4'd0, 0, 16'h0); endtask
  task automatic key(input logic [3:0] v, input logic nx); step(0, 0, 0, nx, 1, v, 0, 16'h0); endtask
  task automatic load(input logic [15:0] s);    step(0, 0, 0, 0, 0, 4'd0, 1, s); endtask

  // Types a full guess, advancing the cursor with each key (ends back at 0).
  task automatic enter(input logic [15:0] g);
    for (int i = 0; i < 4; i++) key(4'((g >> (4*i)) & 16'hF), 1'b1);
  endtask

  initial begin
    model_reset();
    step(1, 0, 0, 0, 0, 4'd0, 0, 16'h0);
    step(1, 0, 0, 0, 0, 4'd0, 0, 16'h0);
    check("reset_digits", 32'(digits_out), 32'hFFFF);
    check("reset_state", 32'(state_code), 32'd0);

    // Idle ignores everything but new game.
    submit(); key(4'd3, 1'b1); load(16'h1234);

    // Round 1: secret arrives two cycles after new game.
    new_game(); idle(); load(16'h7642);
    check("entry_msg", 32'(msg_code), 32'd1);
    key(4'd2, 0); next(); key(4'd4, 0); next();
    key(4'd6, 1'b1);                             // write at 2, then cursor to 3
    key(4'hB, 0);                                // ignored
    submit();                                    // digit 3 still blank: ignored
    check("blank_submit_ignored", 32'(state_code), 32'd2);
    key(4'd7, 0);
    check("entry_digits", 32'(digits_out), 32'h7642);
    next();
    check("cursor_wrap", 32'(cursor), 32'd0);
    submit();
    check("check_state", 32'(state_code), 32'd3);
    idle();
    check("win_feedback", 32'(feedback), 32'h492);
    check("win_msg", 32'(msg_code), 32'hA);
    idle(); submit(); key(4'd1, 1'b1);           // WIN holds

    // Round 2: graded feedback then back to entry.
    new_game(); load(16'h5555);
    enter(16'h9130); submit(); idle();
    check("fb_9130", 32'(feedback), 32'h849);
    check("feedback_state", 32'(state_code), 32'd4);
    key(4'd2, 1'b1); next();                     // ignored in FEEDBACK
    submit();
    check("back_to_entry", 32'(digits_out), 32'hFFFF);

    // Round 3: seven wrong guesses lose.
    new_game(); load(16'h5555);
    for (int t = 0; t < MAX_TRIES; t++) begin
      enter(16'h1234); submit(); idle();
      if (t < MAX_TRIES - 1) submit();
    end
    check("lose_flag", 32'(lose), 32'd1);
    check("lose_msg", 32'(msg_code), 32'hD);
    check("lose_tries", 32'(tries_used), 32'd7);
    submit(); idle();
    new_game();
    check("restart_tries", 32'(tries_used), 32'd0);
    new_game();                                  // ignored in LOAD

    // Round 4: out-of-range secret nibbles are folded; 7423 must win.
    load(16'hFCA3);
    enter(16'h7423); submit(); idle();
    check("folded_secret_win", 32'(win), 32'd1);

    // Reset mid-entry with a secret strobe on the same cycle.
    new_game(); load(16'h1111); key(4'd5, 1'b1);
    step(1, 0, 0, 0, 0, 4'd0, 1, 16'h2222);
    check("midreset_digits", 32'(digits_out), 32'hFFFF);
    check("midreset_state", 32'(state_code), 32'd0);

    // Random traffic; often types the true secret so wins also occur.
    for (int n = 0; n < 3000; n++) begin
      logic [3:0] kv_val;
      kv_val = 4'($urandom_range(0, 15));
      if (m_state == 2 && $urandom_range(0, 1) == 1) kv_val = 4'(m_sec[m_cur]);
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 79) == 0),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 1) == 1), kv_val,
           ($urandom_range(0, 3) == 0), 16'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
